fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the word-addressed instruction memory. The memory has a registered address and a one-cycle read latency.
- Owns the PC and issues one word address per cycle.
- Absorbs the memory latency and hands {pc, instruction} to decode over a valid/ready handshake.
- Decode-side back-pressure is absorbed by a 2-entry output buffer.
- A redirect from execute flushes all wrong-path words and restarts fetch at a new target.

Parameters:
DATA_WIDTH, 32, instruction/data word width
ADDR_WIDTH, 8, instruction memory word-address width (memory depth 2**ADDR_WIDTH words)
RESET_PC, 32'h0000_0000, byte address of first fetch after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_enable  input  1  when 0, no new addresses issued; in-flight and buffered words still delivered
redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  byte target; bits[1:0] ignored (treated as 0)
imem_address  output  ADDR_WIDTH  word address to memory = issue_pc[ADDR_WIDTH+1:2]
imem_read_data  input  DATA_WIDTH  memory data for the address issued in the previous cycle
instr_valid  output  1  instr_data/instr_pc hold a valid word
instr_ready  input  1  decode accepts when instr_valid && instr_ready
instr_data  output  DATA_WIDTH  fetched instruction
instr_pc  output  32  byte address of instr_data

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC; inflight_q=0; buffer count=0.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - Reset mid-operation drops any in-flight word; the memory's stale output is ignored because inflight_q=0.
- State:
  - pc_q: next sequential byte address.
  - inflight_q / inflight_pc_q: a request was issued last cycle.
  - Buffer: 2-entry FIFO of {pc, data}. Head drives instr_*.
  - instr_valid = (count != 0). No combinational path from imem_read_data to instr_*.
- Issue pc (combinational): issue_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q. imem_address is always driven from issue_pc, even when no issue occurs.
- Issue condition, without redirect: issue = fetch_enable && (count + inflight_q - pop) < 2, where pop = instr_valid && instr_ready.
  - This credit rule guarantees a returning word always finds a free slot.
  - On issue: pc_q <= issue_pc + 4; inflight_q <= 1; inflight_pc_q <= issue_pc.
  - No issue: pc_q holds; inflight_q <= 0.
- Response: if inflight_q && !redirect_valid, push {inflight_pc_q, imem_read_data} this cycle.
- Simultaneous push and pop is allowed; count unchanged.
- Throughput: with instr_ready held 1, one instruction per cycle. First instr_valid occurs 2 cycles after reset release (issue cycle 0, push at end of cycle 1, visible cycle 2).
- Redirect (redirect_valid=1):
  - Buffer is flushed (count<=0), including a head being popped that cycle; that pop still counts as accepted by decode.
  - The in-flight response is discarded.
  - Issue of the target occurs the same cycle if fetch_enable=1, regardless of credits.
  - pc_q <= target+4. If fetch_enable=0, pc_q <= target and nothing is issued.
  - First target word is visible at instr_* 2 cycles after the redirect cycle.
- Back-pressure: instr_ready=0 holds instr_* stable. Buffer fills to 2 and issue stops. No word is lost or duplicated.
- fetch_enable deassert: stops new issues only. The outstanding word is still pushed, and pc_q holds the next address for resume.
- Wrap-around:
  - pc_q increments modulo 2**32 (0xFFFF_FFFC+4 = 0).
  - imem_address truncates, so fetch past memory top aliases to word 0.
- Fetch never writes memory; the memory write port is driven elsewhere.

Test Plan:
- Memory preloaded words 0..4 = 01900093, 02C00113, 002081B3, 00300023, FFFFFFF6; RESET_PC=0; ready=1. Release reset -> instr_valid rises cycle 2; then (pc,data) = (0,01900093),(4,02C00113),(8,002081B3),(C,00300023),(10,FFFFFFF6) on consecutive cycles.
- Hold instr_ready=0 from cycle 2 for 5 cycles -> instr_pc stays 0, at most 2 words buffered, imem_address stops advancing. Release -> pcs 0,4,8,C delivered in order, no gaps or duplicates.
- Redirect_valid with redirect_pc=0x0000000E while words 4 and 8 are buffered or in flight -> imem_address=3 that cycle, buffer emptied, two cycles later (pc,data)=(C,00300023), then (10,FFFFFFF6).
- Redirect in the same cycle as a pop -> popped word counted once, nothing else from the old path appears.
- fetch_enable=0 after first issue -> exactly one more word delivered, then instr_valid=0. Re-enable -> fetch resumes at the next sequential pc.
- Assert rst_n=0 mid-stream with ready=0 and buffer full -> instr_valid=0 immediately (async). After release, the sequence restarts at pc 0 with no stale word; ADDR_WIDTH=3 run wraps pc 0x20 to imem_address 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Decode-side handshake between the fetch stage and decode: {pc, instruction} under valid/ready.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [31:0]           instr_pc;

  modport master (output instr_valid, output instr_data, output instr_pc, input instr_ready);
  modport slave  (input instr_valid, input instr_data, input instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one word address per cycle to a 1-cycle-latency memory,
// and delivers {pc, instruction} to decode through a 2-entry buffer with redirect flush.
module fetch_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  fetch_unit_if.master          dec
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CRED_W  = 3;

  logic [31:0]           pc_q, pc_d, issue_pc;
  logic                  inflight_q;
  logic [31:0]           inflight_pc_q;
  logic [31:0]           buf_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q;
  logic                  pop, push, issue, wr_idx;
  logic [CRED_W-1:0]     credits;

  // Issue/credit/buffer next-state; credits guarantee a returning word always has a free slot.
  always_comb begin
    issue_pc = redirect_valid ? (redirect_pc & ~32'd3) : pc_q;
    pop      = valid_q && dec.instr_ready;
    push     = inflight_q && !redirect_valid;
    credits  = CRED_W'(count_q) + CRED_W'(inflight_q) - CRED_W'(pop);
    issue    = fetch_enable && (redirect_valid || (credits < CRED_W'(2)));
    wr_idx   = 1'(count_q - CNT_W'(pop));

    pc_d = pc_q;
    if (issue)               pc_d = issue_pc + 32'd4;
    else if (redirect_valid) pc_d = issue_pc;

    count_d = count_q;
    if (redirect_valid)      count_d = '0;
    else if (push && !pop)   count_d = count_q + CNT_W'(1);
    else if (pop && !push)   count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= issue_pc;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      // Shift-out on pop; a simultaneous push lands in the slot freed behind the new head.
      if (pop) begin
        buf_pc_q[0]   <= buf_pc_q[1];
        buf_data_q[0] <= buf_data_q[1];
      end
      if (push) begin
        buf_pc_q[wr_idx]   <= inflight_pc_q;
        buf_data_q[wr_idx] <= imem_read_data;
      end
    end
  end

  assign imem_address    = issue_pc[ADDR_WIDTH+1:2];
  assign dec.instr_valid = valid_q;
  assign dec.instr_pc    = buf_pc_q[0];
  assign dec.instr_data  = buf_data_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected {pc,data} stream per fetch path vs. monitor.
module tb_fetch_unit;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned AW3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, fetch_enable, redirect_valid;
  logic [31:0]    redirect_pc;
  logic [AW-1:0]  imem_address;
  logic [DW-1:0]  imem_read_data;
  logic [DW-1:0]  mem [256];

  logic [AW3-1:0] imem_address3;
  logic [DW-1:0]  imem_read_data3;
  logic [DW-1:0]  mem3 [8];

  fetch_unit_if #(.DATA_WIDTH(DW)) dif ();
  fetch_unit_if #(.DATA_WIDTH(DW)) dif3 ();

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_address(imem_address), .imem_read_data(imem_read_data),
    .dec(dif));

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW3), .RESET_PC(32'h0000_0020)) dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_enable(1'b1), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_address(imem_address3), .imem_read_data(imem_read_data3),
    .dec(dif3));

  always @(posedge clk) imem_read_data  <= mem[imem_address];
  always @(posedge clk) imem_read_data3 <= mem3[imem_address3];

  typedef struct {
    int unsigned epoch;
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned gen_epoch = 0;
  int unsigned cur_epoch = 0;
  logic [31:0] gen_pc;
  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Keep at least 8 expected words of the current fetch path queued.
  task automatic topup();
    int   live;
    exp_t e;
    live = 0;
    foreach (sb[i]) if (sb[i].epoch == gen_epoch) live++;
    while (live < 8) begin
      e.epoch = gen_epoch;
      e.pc    = gen_pc;
      e.data  = mem[gen_pc[AW+1:2]];
      sb.push_back(e);
      gen_pc = gen_pc + 32'd4;
      live++;
    end
  endtask

  task automatic new_path(input logic [31:0] pc);
    gen_epoch++;
    gen_pc = pc & ~32'd3;
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    topup();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    new_path(pc);
  endtask

  // Monitor: compares every accepted word, and checks stability while stalled.
  bit          hold = 1'b0;
  logic [31:0] hold_pc, hold_data;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_epoch = gen_epoch;
      hold      = 1'b0;
      check("reset_valid_low", 32'(dif.instr_valid), 32'd0);
    end else begin
      if (hold) begin
        check("stall_valid", 32'(dif.instr_valid), 32'd1);
        check("stall_pc", dif.instr_pc, hold_pc);
        check("stall_data", dif.instr_data, hold_data);
      end
      if (dif.instr_valid && dif.instr_ready) begin
        while (sb.size() > 0 && sb[0].epoch != cur_epoch) void'(sb.pop_front());
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty actual=word pc %h required=no word at %0t", dif.instr_pc, $time);
        end else begin
          mon_e = sb.pop_front();
          check("acc_pc", dif.instr_pc, mon_e.pc);
          check("acc_data", dif.instr_data, mon_e.data);
        end
        n_acc++;
      end
      hold      = dif.instr_valid && !dif.instr_ready;
      hold_pc   = dif.instr_pc;
      hold_data = dif.instr_data;
      if (redirect_valid) begin
        cur_epoch = gen_epoch;
        hold      = 1'b0;
      end
    end
  end

  logic [AW-1:0] addr_snap;
  int            acc0;
  logic [31:0]   r;

  initial begin
    rst_n            = 1'b0;
    fetch_enable     = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    dif.instr_ready  = 1'b1;
    dif3.instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0190_0093;
    mem[1] = 32'h02C0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0030_0023;
    mem[4] = 32'hFFFF_FFF6;
    for (int i = 0; i < 8; i++) mem3[i] = $urandom;
    gen_pc = 32'h0;
    topup();

    repeat (3) step();
    check("rst_valid", 32'(dif.instr_valid), 32'd0);
    check("rst_data", dif.instr_data, 32'h0);
    check("rst_pc", dif.instr_pc, 32'h0);

    // Release: issue in cycle 0, visible in cycle 2
    rst_n = 1'b1;
    #1;
    check("release_addr", 32'(imem_address), 32'd0);
    check("aw3_wrap_addr", 32'(imem_address3), 32'd0);
    step();
    check("first_valid_c1", 32'(dif.instr_valid), 32'd0);
    step();
    check("first_valid_c2", 32'(dif.instr_valid), 32'd1);
    check("first_pc", dif.instr_pc, 32'h0);
    check("aw3_valid", 32'(dif3.instr_valid), 32'd1);
    check("aw3_pc", dif3.instr_pc, 32'h0000_0020);
    check("aw3_data", dif3.instr_data, mem3[0]);
    repeat (6) step();

    // Back-pressure
    dif.instr_ready = 1'b0;
    repeat (3) step();
    addr_snap = imem_address;
    repeat (2) step();
    check("bp_addr_frozen", 32'(imem_address), 32'(addr_snap));
    check("bp_valid", 32'(dif.instr_valid), 32'd1);
    dif.instr_ready = 1'b1;
    repeat (6) step();

    // Redirect to 0xE with a coincident pop
    redirect(32'h0000_000E);
    #1;
    check("redirect_addr", 32'(imem_address), 32'd3);
    step();
    check("redirect_flush", 32'(dif.instr_valid), 32'd0);
    step();
    check("redirect_valid2", 32'(dif.instr_valid), 32'd1);
    check("redirect_pc2", dif.instr_pc, 32'h0000_000C);
    repeat (4) step();

    // Async reset with a full buffer
    dif.instr_ready = 1'b0;
    repeat (4) step();
    check("full_before_rst", 32'(dif.instr_valid), 32'd1);
    rst_n = 1'b0;
    new_path(32'h0);
    #1;
    check("async_rst_valid", 32'(dif.instr_valid), 32'd0);
    step();
    step();
    dif.instr_ready = 1'b1;
    rst_n = 1'b1;

    // fetch_enable drop right after the first issue: exactly one word delivered
    step();
    fetch_enable = 1'b0;
    acc0 = n_acc;
    repeat (5) step();
    check("fe_off_count", 32'(n_acc - acc0), 32'd1);
    check("fe_off_valid", 32'(dif.instr_valid), 32'd0);
    fetch_enable = 1'b1;
    repeat (8) step();

    // Randomized traffic
    acc0 = n_acc;
    repeat (800) begin
      step();
      dif.instr_ready = ($urandom_range(0, 9) < 7);
      fetch_enable    = ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 19) == 0) begin
        r = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'($urandom);
        redirect(r);
      end
    end
    step();
    dif.instr_ready = 1'b1;
    fetch_enable    = 1'b1;
    repeat (10) step();
    check("random_progress", 32'(n_acc - acc0 > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
